// File: rtl/tone_sample_formatter.sv
// Tone-to-PCM formatter: synchronises a square-wave tone, samples it every SAMPLE_DIV clocks and
// presents signed samples on valid/ready. Define TONE_SAMPLE_SOFT_RAMP_EN for ramped amplitude.
module tone_sample_formatter #(
  parameter int                      SAMPLE_WIDTH = 16,
  parameter logic [SAMPLE_WIDTH-1:0] AMPLITUDE    = 16'h2000,
  parameter int                      SAMPLE_DIV   = 1042,
  parameter int                      SYNC_STAGES  = 2,
  parameter logic [SAMPLE_WIDTH-1:0] RAMP_STEP    = 16'h0100
) (
  input  logic                           inclk,
  input  logic                           Reset,
  input  logic                           tone_in,
  input  logic                           tone_enable,
  output logic signed [SAMPLE_WIDTH-1:0] sample_data,
  output logic                           sample_valid,
  input  logic                           sample_ready,
  output logic                           overrun
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [SAMPLE_WIDTH-1:0] POS_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};

  generate
    if (AMPLITUDE > POS_MAX) begin : g_bad_amplitude
      $error("AMPLITUDE exceeds the positive sample range");
    end
    if (RAMP_STEP > POS_MAX) begin : g_bad_ramp_step
      $error("RAMP_STEP exceeds the positive sample range");
    end
    if (SAMPLE_DIV < 2) begin : g_bad_div
      $error("SAMPLE_DIV must be at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
    end
  endgenerate

  typedef enum logic {IDLE, HOLD} state_t;

  function automatic logic signed [SAMPLE_WIDTH-1:0] to_pcm(
    input logic                    tone,
    input logic [SAMPLE_WIDTH-1:0] mag
  );
    logic signed [SAMPLE_WIDTH-1:0] m;
    m = $signed(mag);
    return tone ? m : -m;
  endfunction

  logic [SYNC_STAGES-1:0]         sync_q, sync_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  state_t                         state_q, state_d;
  logic signed [SAMPLE_WIDTH-1:0] data_q, data_d;
  logic                           valid_q, valid_d;
  logic                           ovr_q, ovr_d;
  logic                           tick;
  logic [SAMPLE_WIDTH-1:0]        mag;
  logic signed [SAMPLE_WIDTH-1:0] pcm;

`ifdef TONE_SAMPLE_SOFT_RAMP_EN
  logic [SAMPLE_WIDTH-1:0] amp_q, amp_d;

  // Saturating step toward AMPLITUDE (up) or toward zero (down).
  function automatic logic [SAMPLE_WIDTH-1:0] ramp_toward(
    input logic [SAMPLE_WIDTH-1:0] amp,
    input logic                    up
  );
    logic [SAMPLE_WIDTH:0] sum;
    sum = {1'b0, amp} + {1'b0, RAMP_STEP};
    if (up) return (sum > {1'b0, AMPLITUDE}) ? AMPLITUDE : sum[SAMPLE_WIDTH-1:0];
    return (amp > RAMP_STEP) ? (amp - RAMP_STEP) : '0;
  endfunction

  always_comb begin
    amp_d = tick ? ramp_toward(amp_q, tone_enable) : amp_q;
    mag   = amp_d;
  end
`else
  always_comb begin
    mag = tone_enable ? AMPLITUDE : '0;
  end
`endif

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], tone_in};
    tick   = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    pcm    = to_pcm(sync_q[SYNC_STAGES-1], mag);
  end

  // A tick in HOLD either replaces the pending sample (when it is taken this edge) or is dropped.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = HOLD;
          data_d  = pcm;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (tick && sample_ready) begin
          data_d = pcm;
        end else if (tick) begin
          ovr_d = 1'b1;
        end else if (sample_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge inclk or posedge Reset) begin
    if (Reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef TONE_SAMPLE_SOFT_RAMP_EN
      amp_q   <= '0;
`endif
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef TONE_SAMPLE_SOFT_RAMP_EN
      amp_q   <= amp_d;
`endif
    end
  end

  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_tone_sample_formatter.sv
// Self-checking bench for tone_sample_formatter: directed scenarios with literal expectations
// plus randomized stimulus against a cycle-level behavioural model.
module tb_tone_sample_formatter;

  localparam int          DIV  = 8;
  localparam int          SYNC = 2;
  localparam logic [15:0] AMP  = 16'h2000;
  localparam logic [15:0] STEP = 16'h0800;

  logic        inclk = 1'b0;
  logic        Reset = 1'b1;
  logic        tone_in = 1'b0;
  logic        tone_enable = 1'b0;
  logic        sample_ready = 1'b0;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  tone_sample_formatter #(
    .SAMPLE_WIDTH(16),
    .AMPLITUDE   (AMP),
    .SAMPLE_DIV  (DIV),
    .SYNC_STAGES (SYNC),
    .RAMP_STEP   (STEP)
  ) dut (
    .inclk       (inclk),
    .Reset       (Reset),
    .tone_in     (tone_in),
    .tone_enable (tone_enable),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun     (overrun)
  );

  always #5 inclk = ~inclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_edges;
  int   m_amp;
  logic m_valid;
  logic m_ovr;
  logic [15:0] m_data;
  logic tlog [64];

  function automatic logic f_tick(input int e);
    return (e % DIV) == DIV - 1;
  endfunction

  // tone as seen after the synchroniser at edge n: tone_in sampled SYNC edges earlier
  function automatic logic f_tone_s(input int n);
    if (n - SYNC < 1) return 1'b0;
    return tlog[(n - SYNC) % 64];
  endfunction

  function automatic int f_amp(input int amp, input logic en);
    if (en) return (amp + int'(STEP) > int'(AMP)) ? int'(AMP) : amp + int'(STEP);
    return (amp < int'(STEP)) ? 0 : amp - int'(STEP);
  endfunction

  function automatic int f_mag(input int amp, input logic en);
`ifdef TONE_SAMPLE_SOFT_RAMP_EN
    return f_amp(amp, en);
`else
    return en ? int'(AMP) : 0;
`endif
  endfunction

  function automatic logic [15:0] f_pcm(input logic ts, input int mag);
    int s;
    s = ts ? mag : -mag;
    return s[15:0];
  endfunction

  always @(posedge inclk or posedge Reset) begin
    if (Reset) begin
      m_edges <= 0;
      m_amp   <= 0;
      m_valid <= 1'b0;
      m_ovr   <= 1'b0;
      m_data  <= '0;
    end else begin
      m_edges <= m_edges + 1;
      tlog[(m_edges + 1) % 64] <= tone_in;
      if (f_tick(m_edges)) begin
        m_amp <= f_amp(m_amp, tone_enable);
        if (!m_valid || sample_ready) begin
          m_valid <= 1'b1;
          m_data  <= f_pcm(f_tone_s(m_edges + 1), f_mag(m_amp, tone_enable));
        end else begin
          m_ovr <= 1'b1;
        end
      end else if (sample_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge inclk) begin
    if (!Reset) begin
      chk("mdl_valid", {31'd0, sample_valid}, {31'd0, m_valid});
      chk("mdl_data", {16'd0, sample_data}, {16'd0, m_data});
      chk("mdl_overrun", {31'd0, overrun}, {31'd0, m_ovr});
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic rst_pulse();
    @(negedge inclk);
    Reset = 1'b1;
    @(negedge inclk);
    Reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge inclk);
    @(negedge inclk);
  endtask

  logic [15:0] exp_up [5];
  logic [15:0] exp_dn [4];
  logic [15:0] first_pos;
  logic [15:0] first_neg;
  logic [15:0] third_neg;

  initial begin
`ifdef TONE_SAMPLE_SOFT_RAMP_EN
    exp_up    = '{16'h0800, 16'h1000, 16'h1800, 16'h2000, 16'h2000};
    exp_dn    = '{16'h1800, 16'h1000, 16'h0800, 16'h0000};
    first_pos = 16'h0800;
    first_neg = 16'hF800;
    third_neg = 16'hE800;
`else
    exp_up    = '{16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000};
    exp_dn    = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    first_pos = 16'h2000;
    first_neg = 16'hE000;
    third_neg = 16'hE000;
`endif

    // positive tone, consumer always ready, then mute
    tone_in = 1'b1; tone_enable = 1'b1; sample_ready = 1'b1;
    rst_pulse();
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_data", {16'd0, sample_data}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    step(7);
    chk("t1_pre_tick_valid", {31'd0, sample_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t1_valid", {31'd0, sample_valid}, 32'd1);
      chk("t1_data", {16'd0, sample_data}, {16'd0, exp_up[i]});
      chk("t1_overrun", {31'd0, overrun}, 32'd0);
      step(1);
      chk("t1_accepted", {31'd0, sample_valid}, 32'd0);
      step(6);
    end
    tone_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t1_mute_data", {16'd0, sample_data}, {16'd0, exp_dn[i]});
      step(7);
    end

    // negative tone, then mute
    tone_in = 1'b0; tone_enable = 1'b1; sample_ready = 1'b1;
    rst_pulse();
    step(8);
    chk("t2_neg_data", {16'd0, sample_data}, {16'd0, first_neg});
    tone_enable = 1'b0;
    step(8);
    chk("t2_mute_data", {16'd0, sample_data}, 32'd0);

    // consumer stalls across two ticks
    tone_in = 1'b1; tone_enable = 1'b1; sample_ready = 1'b0;
    rst_pulse();
    step(8);
    chk("t3_first_valid", {31'd0, sample_valid}, 32'd1);
    chk("t3_first_data", {16'd0, sample_data}, {16'd0, first_pos});
    tone_in = 1'b0;
    step(8);
    chk("t3_hold_data", {16'd0, sample_data}, {16'd0, first_pos});
    chk("t3_hold_valid", {31'd0, sample_valid}, 32'd1);
    chk("t3_overrun", {31'd0, overrun}, 32'd1);
    sample_ready = 1'b1;
    step(1);
    chk("t3_drain_valid", {31'd0, sample_valid}, 32'd0);
    chk("t3_overrun_sticky", {31'd0, overrun}, 32'd1);
    sample_ready = 1'b0;

    // ready raised exactly in a tick cycle while holding a sample
    step(7);
    chk("t4_load_valid", {31'd0, sample_valid}, 32'd1);
    chk("t4_load_data", {16'd0, sample_data}, {16'd0, third_neg});
    tone_in = 1'b1;
    step(7);
    sample_ready = 1'b1;
    step(1);
    chk("t4_reload_valid", {31'd0, sample_valid}, 32'd1);
    chk("t4_reload_data", {16'd0, sample_data}, 32'h2000);
    sample_ready = 1'b0;

    // asynchronous reset between clock edges while holding
    @(posedge inclk);
    #2 Reset = 1'b1;
    #1;
    chk("t5_async_valid", {31'd0, sample_valid}, 32'd0);
    chk("t5_async_data", {16'd0, sample_data}, 32'd0);
    chk("t5_async_overrun", {31'd0, overrun}, 32'd0);
    tone_in = 1'b1; tone_enable = 1'b1; sample_ready = 1'b1;
    @(negedge inclk);
    Reset = 1'b0;
    step(7);
    chk("t5_pre_tick_valid", {31'd0, sample_valid}, 32'd0);
    step(1);
    chk("t5_first_valid", {31'd0, sample_valid}, 32'd1);
    chk("t5_first_data", {16'd0, sample_data}, {16'd0, first_pos});

    // randomized traffic, with occasional mid-cycle resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) tone_in = ~tone_in;
      if ($urandom_range(0, 99) == 0) tone_enable = ~tone_enable;
      sample_ready = ($urandom_range(0, 9) < 3);
      if (i % 1000 == 999) begin
        #2 Reset = 1'b1;
        @(negedge inclk);
        Reset = 1'b0;
      end else begin
        @(negedge inclk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tone_sample_formatter.md
Name: tone_sample_formatter

Overview:
- Sits directly downstream of the tone-select mux. Consumes the selected square-wave tone and turns it into signed PCM samples for the audio codec path.
- Synchronises the tone into the system clock domain, samples it at a fixed audio rate, maps high/low/muted to +A/-A/0, and presents each sample on a valid/ready handshake.

Parameters:
- SAMPLE_WIDTH, 16: sample word width, two's complement.
- AMPLITUDE, 16'h2000: peak magnitude. Must be ≤ 2^(SAMPLE_WIDTH-1)-1.
- SAMPLE_DIV, 1042: inclk cycles per sample tick (50 MHz / 48 kHz). Must be ≥ 2.
- SYNC_STAGES, 2: flops in the tone_in synchroniser. Must be ≥ 2.
- RAMP_STEP, 16'h0100: amplitude change per tick. Used only with the optional feature.

Ports:
- inclk  in  1  system clock, 50 MHz, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- tone_in  in  1  selected square-wave tone. Asynchronous to inclk.
- tone_enable  in  1  1 = play, 0 = mute (sample value 0).
- sample_data  out  SAMPLE_WIDTH  current sample, two's complement.
- sample_valid  out  1  sample_data holds an unaccepted sample.
- sample_ready  in  1  consumer accepts the sample at a rising edge where valid & ready.
- overrun  out  1  sticky. A tick arrived while the previous sample was still pending.

Behaviour:
- Reset: all outputs 0; synchroniser flops 0; tick counter 0; state IDLE; ramp amplitude 0. Reset takes effect immediately and asynchronously, including mid-handshake; a pending sample is discarded.
- Synchroniser: tone_in passes through SYNC_STAGES flops, giving tone_s. No other logic reads tone_in.
- Tick counter: counts 0..SAMPLE_DIV-1 and wraps to 0. tick = 1 for the single cycle where count == SAMPLE_DIV-1. Runs continuously and is independent of the handshake.
- Sample value on tick:
  - if !tone_enable: 0
  - else if tone_s: +AMPLITUDE
  - else: -AMPLITUDE, as the SAMPLE_WIDTH-bit two's complement of AMPLITUDE.
- Latency: the sample registers at the tick edge; sample_valid rises on the same edge, so it is visible the cycle after the tick.
- State machine:
  - IDLE (valid=0) --tick--> HOLD: load sample_data, valid=1.
  - HOLD, valid & ready, no tick --> IDLE: valid=0. sample_data keeps its last value.
  - HOLD, valid & ready & tick in the same cycle --> stay HOLD: load the new sample; valid stays 1.
  - HOLD, tick & !ready --> stay HOLD: new sample dropped, sample_data unchanged, overrun=1.
  - HOLD, no tick & !ready --> stay HOLD, no change.
- sample_data is stable whenever sample_valid=1 and no transfer has occurred.
- overrun clears only on Reset.
- sample_ready while in IDLE is ignored.
- tone_enable is sampled only at ticks; toggling it between ticks has no effect.

Optional Feature:
- Macro: TONE_SAMPLE_SOFT_RAMP_EN.
- Defined: an internal amplitude register amp (reset 0) replaces the fixed AMPLITUDE. On each tick:
  - amp moves toward AMPLITUDE by RAMP_STEP when tone_enable=1, saturating at AMPLITUDE.
  - amp moves toward 0 by RAMP_STEP when tone_enable=0, saturating at 0.
  - The sample is +amp or -amp per tone_s, using the amp value after this tick's update.
  - 0 when amp == 0.
- Undefined: amplitude steps instantly as described above; amp and RAMP_STEP logic are absent.

Test Plan (SAMPLE_DIV=8, AMPLITUDE=16'h2000, SYNC_STAGES=2):
1. Reset released; tone_in=1, tone_enable=1, ready held 1 -> first valid at cycle 8 with data 16'h2000, then one 1-cycle valid pulse every 8 cycles; overrun stays 0.
2. tone_in=0, enable=1, ready=1 -> data 16'hE000 at each tick. Then enable=0 -> next tick data 16'h0000.
3. ready=0 across two ticks, tone_in toggled between them -> data holds the first sample, valid stays 1, overrun=1 after the second tick. Then ready=1 for one cycle -> valid=0 the next cycle; overrun stays 1.
4. ready rises exactly on a tick cycle while in HOLD -> transfer and reload on the same edge; valid stays 1 and data shows the new sample.
5. Reset asserted mid-HOLD, asynchronously, between clock edges -> valid, data and overrun go to 0 immediately. After release, the first tick is 8 cycles later.
6. With TONE_SAMPLE_SOFT_RAMP_EN, RAMP_STEP=16'h0800, tone_in=1, enable=1 -> successive samples 16'h0800, 1000, 1800, 2000, 2000. Then enable=0 -> 16'h1800, 1000, 0800, 0000.
